oled_pixel_streamer: RTL

//   Frame-scan and serial-out engine for the 96x64 RGB565 OLED. Walks pixel_index over
//   the frame, samples pixel_data from the combinational pixel source (the sort and bar

---
 rtl/oled_pixel_streamer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/oled_pixel_streamer.sv
// Frame-scan and serial-out engine for a WIDTHxHEIGHT RGB565 OLED: walks pixel_index, samples
// pixel_data and shifts each word out MSB-first on cs/sdin/sclk. Optional macro: OLED_BYTE_SWAP_EN.
module oled_pixel_streamer #(
   parameter int WIDTH     = 96,
   parameter int HEIGHT    = 64,
   parameter int FRAME_GAP = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] pixel_data,
   output logic        frame_begin,
   output logic        sending_pixels,
   output logic        sample_pixel,
   output logic [12:0] pixel_index,
   output logic        frame_done,
   output logic        cs,
   output logic        sdin,
   output logic        sclk,
   output logic [2:0]  dbg_state
);

   localparam int          NPIX     = WIDTH * HEIGHT;
   localparam logic [12:0] LAST_IDX = 13'(NPIX - 1);
   localparam int          CW       = (FRAME_GAP > 32) ? $clog2(FRAME_GAP) : 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FRAME_START,
      S_SAMPLE,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t        state;
   logic [14:0]   shreg;
   logic [CW-1:0] cnt;
   logic [15:0]   word;

   assign dbg_state = state;

`ifdef OLED_BYTE_SWAP_EN
   assign word = {pixel_data[7:0], pixel_data[15:8]};
`else
   assign word = pixel_data;
`endif

   // In SHIFT, cnt[4:1] counts bits already sent and cnt[0] is the sclk phase.
   // sdin is loaded one cycle ahead so it is settled for the whole low phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         cs             <= 1'b1;
         sclk           <= 1'b0;
         sdin           <= 1'b0;
         pixel_index    <= '0;
         frame_begin    <= 1'b0;
         sample_pixel   <= 1'b0;
         frame_done     <= 1'b0;
         sending_pixels <= 1'b0;
         shreg          <= '0;
         cnt            <= '0;
      end else begin
         frame_begin  <= 1'b0;
         sample_pixel <= 1'b0;
         frame_done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state       <= S_FRAME_START;
                  frame_begin <= 1'b1;
                  pixel_index <= '0;
               end
            end
            S_FRAME_START: begin
               state          <= S_SAMPLE;
               sample_pixel   <= 1'b1;
               sending_pixels <= 1'b1;
               cs             <= 1'b0;
            end
            S_SAMPLE: begin
               state <= S_SHIFT;
               shreg <= word[14:0];
               sdin  <= word[15];
               cnt   <= '0;
            end
            S_SHIFT: begin
               cnt <= cnt + 1'b1;
               if (!cnt[0]) begin
                  sclk <= 1'b1;
               end else begin
                  sclk <= 1'b0;
                  if (cnt == CW'(31)) begin
                     if (pixel_index < LAST_IDX) begin
                        pixel_index  <= pixel_index + 13'd1;
                        state        <= S_SAMPLE;
                        sample_pixel <= 1'b1;
                     end else begin
                        state          <= S_GAP;
                        frame_done     <= 1'b1;
                        cs             <= 1'b1;
                        sending_pixels <= 1'b0;
                        cnt            <= '0;
                     end
                  end else begin
                     shreg <= {shreg[13:0], 1'b0};
                     sdin  <= shreg[14];
                  end
               end
            end
            S_GAP: begin
               if (cnt == CW'(FRAME_GAP - 1)) begin
                  cnt         <= '0;
                  pixel_index <= '0;
                  if (enable) begin
                     state       <= S_FRAME_START;
                     frame_begin <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
